// File: rtl/flash_arbiter_if.sv
// Bus between the Flash arbiter, its client requesters and the Flash bridge.
// The arbiter takes the slave view; clients plus the bridge take the master view.
interface flash_arbiter_if #(
    parameter int NREQ = 2
) ();

    logic [NREQ-1:0]   req_i;
    logic [NREQ-1:0]   req_rw_i;
    logic [8*NREQ-1:0] req_addr_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   grant_o;
    logic [NREQ-1:0]   ack_o;
    logic [NREQ-1:0]   err_o;
    logic              busy_o;
    logic [7:0]        fb_addr_o;
    logic [7:0]        fb_data_o;
    logic              fb_rw_o;
    logic              fb_start_o;
    logic              fb_done_i;

    modport slave (
        input  req_i, req_rw_i, req_addr_i, req_data_i, fb_done_i,
        output grant_o, ack_o, err_o, busy_o, fb_addr_o, fb_data_o, fb_rw_o, fb_start_o
    );

    modport master (
        output req_i, req_rw_i, req_addr_i, req_data_i, fb_done_i,
        input  grant_o, ack_o, err_o, busy_o, fb_addr_o, fb_data_o, fb_rw_o, fb_start_o
    );

endinterface

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing the single Flash bridge port between NREQ clients.
// The winner's address, data and direction are latched at grant and held for the
// whole access; every access is watched by a saturating timeout counter.
module flash_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic           CLK_50MHZ,
    input  logic           RST,
    flash_arbiter_if.slave bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW  = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] last_q;
    logic [IDXW-1:0] owner_q;
    logic [WDW-1:0]  watchdog_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] err_q;
    logic            busy_q;
    logic [7:0]      fbAddr_q;
    logic [7:0]      fbData_q;
    logic            fbRw_q;
    logic            fbStart_q;

    logic            anyReq_d;
    logic [IDXW-1:0] winner_d;
    logic [NREQ-1:0] winnerOneHot_d;
    logic [7:0]      winnerAddr_d;
    logic [7:0]      winnerData_d;
    logic            winnerRw_d;

    // Search requests starting just after the last owner so nobody waits more than one lap.
    always_comb begin : pickWinner
        int              cand;
        logic [IDXW-1:0] candIdx;
        anyReq_d = 1'b0;
        winner_d = '0;
        cand     = 0;
        candIdx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand    = (int'(last_q) + k) % NREQ;
            candIdx = IDXW'(cand);
            if (!anyReq_d && bus.req_i[candIdx]) begin
                anyReq_d = 1'b1;
                winner_d = candIdx;
            end
        end
    end

    // Select the winner's request fields with constant slices.
    always_comb begin
        winnerOneHot_d = '0;
        winnerAddr_d   = 8'h00;
        winnerData_d   = 8'h00;
        winnerRw_d     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_d == IDXW'(i)) begin
                winnerOneHot_d[i] = anyReq_d;
                winnerAddr_d      = bus.req_addr_i[8*i +: 8];
                winnerData_d      = bus.req_data_i[8*i +: 8];
                winnerRw_d        = bus.req_rw_i[i];
            end
        end
    end

    // Access sequencer: grant, start pulse, wait with watchdog, one-cycle release.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q    <= IDLE;
            last_q     <= IDXW'(NREQ - 1);
            owner_q    <= '0;
            watchdog_q <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            fbAddr_q   <= 8'h00;
            fbData_q   <= 8'h00;
            fbRw_q     <= 1'b0;
            fbStart_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq_d) begin
                        grant_q   <= winnerOneHot_d;
                        owner_q   <= winner_d;
                        fbAddr_q  <= winnerAddr_d;
                        fbData_q  <= winnerData_d;
                        fbRw_q    <= winnerRw_d;
                        fbStart_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    fbStart_q  <= 1'b0;
                    watchdog_q <= '0;
                    busy_q     <= 1'b1;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    busy_q <= 1'b1;
                    if (bus.fb_done_i) begin
                        ack_q   <= grant_q;
                        state_q <= RELEASE;
                    end else if (watchdog_q == WD_LAST) begin
                        err_q   <= grant_q;
                        state_q <= RELEASE;
                    end else if (watchdog_q != WD_MAX) begin
                        watchdog_q <= watchdog_q + 1'b1;
                    end
                end
                RELEASE: begin
                    grant_q <= '0;
                    ack_q   <= '0;
                    err_q   <= '0;
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    grant_q   <= '0;
                    ack_q     <= '0;
                    err_q     <= '0;
                    fbStart_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.ack_o      = ack_q;
    assign bus.err_o      = err_q;
    assign bus.busy_o     = busy_q;
    assign bus.fb_addr_o  = fbAddr_q;
    assign bus.fb_data_o  = fbData_q;
    assign bus.fb_rw_o    = fbRw_q;
    assign bus.fb_start_o = fbStart_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a bridge model and an ack/err scoreboard.
module tb_flash_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;

    logic CLK_50MHZ = 1'b0;
    logic RST       = 1'b1;

    // 50 MHz clock.
    always #10 CLK_50MHZ = ~CLK_50MHZ;

    flash_arbiter_if #(.NREQ(NREQ)) bus ();

    flash_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .bus       (bus)
    );

    typedef struct {
        logic [1:0] ack;
        logic [1:0] err;
        logic [7:0] addr;
        logic [7:0] data;
        logic       rw;
        int         latency;
    } exp_t;

    exp_t       sb[$];
    int         errors       = 0;
    int         checks       = 0;
    int         cycleCount   = 0;
    int         startCycle   = 0;
    int         startsSeen   = 0;
    int         bridgeDelay  = 2;
    logic       prevStart    = 1'b0;
    logic [1:0] pendingRaise = 2'b00;
    int         reRaiseLeft[2];
    logic [7:0] addrOf[2];
    logic [7:0] dataOf[2];
    logic       rwOf[2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic rw, input logic [7:0] a, input logic [7:0] d);
        bus.req_rw_i[i]          = rw;
        bus.req_addr_i[8*i +: 8] = a;
        bus.req_data_i[8*i +: 8] = d;
        addrOf[i] = a;
        dataOf[i] = d;
        rwOf[i]   = rw;
    endtask

    task automatic expectDone(input int i, input bit isErr, input int lat);
        exp_t e;
        e.ack     = isErr ? 2'b00 : (2'b01 << i);
        e.err     = isErr ? (2'b01 << i) : 2'b00;
        e.addr    = addrOf[i];
        e.data    = dataOf[i];
        e.rw      = rwOf[i];
        e.latency = lat;
        sb.push_back(e);
    endtask

    // One clock: observe at the falling edge, score ack/err, drop/re-raise requests.
    task automatic stepCycle();
        exp_t e;
        @(negedge CLK_50MHZ);
        cycleCount++;
        for (int i = 0; i < NREQ; i++) begin
            if (pendingRaise[i]) begin
                bus.req_i[i]    = 1'b1;
                pendingRaise[i] = 1'b0;
            end
        end
        if (bus.fb_start_o === 1'b1) begin
            checkOutput("fb_start_pulse", 32'(prevStart), 32'h0);
            startCycle = cycleCount;
            startsSeen++;
        end
        prevStart = bus.fb_start_o;
        if ((bus.ack_o | bus.err_o) !== 2'b00) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'({bus.ack_o, bus.err_o}), 32'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("ack", 32'(bus.ack_o), 32'(e.ack));
                checkOutput("err", 32'(bus.err_o), 32'(e.err));
                checkOutput("grant_owner", 32'(bus.grant_o), 32'(e.ack | e.err));
                checkOutput("fb_addr", 32'(bus.fb_addr_o), 32'(e.addr));
                checkOutput("fb_data", 32'(bus.fb_data_o), 32'(e.data));
                checkOutput("fb_rw", 32'(bus.fb_rw_o), 32'(e.rw));
                checkOutput("latency", 32'(cycleCount - startCycle), 32'(e.latency));
                checkOutput("start_count", 32'(startsSeen), 32'h1);
            end
            startsSeen = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack_o[i] || bus.err_o[i]) begin
                    bus.req_i[i] = 1'b0;
                    if (reRaiseLeft[i] > 0) begin
                        reRaiseLeft[i]--;
                        pendingRaise[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        for (int k = 0; k < maxCycles && sb.size() > 0; k++) stepCycle();
        checkOutput("drain", 32'(sb.size()), 32'h0);
    endtask

    // Bridge model: answers fb_start with a one-cycle fb_done after bridgeDelay cycles (0 = never).
    initial begin
        bus.fb_done_i = 1'b0;
        forever begin
            @(negedge CLK_50MHZ);
            if (bus.fb_start_o === 1'b1 && bridgeDelay > 0) begin
                repeat (bridgeDelay) @(posedge CLK_50MHZ);
                #1 bus.fb_done_i = 1'b1;
                @(posedge CLK_50MHZ);
                #1 bus.fb_done_i = 1'b0;
            end
        end
    end

    // Hard stop in case something hangs.
    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Directed sequence.
    initial begin
        reRaiseLeft = '{0, 0};
        bus.req_i      = '0;
        bus.req_rw_i   = '0;
        bus.req_addr_i = '0;
        bus.req_data_i = '0;
        RST = 1'b1;
        repeat (3) @(negedge CLK_50MHZ);
        checkOutput("rst_grant", 32'(bus.grant_o), 32'h0);
        checkOutput("rst_ack", 32'(bus.ack_o), 32'h0);
        checkOutput("rst_err", 32'(bus.err_o), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy_o), 32'h0);
        checkOutput("rst_fb_start", 32'(bus.fb_start_o), 32'h0);
        checkOutput("rst_fb_rw", 32'(bus.fb_rw_o), 32'h0);
        checkOutput("rst_fb_addr", 32'(bus.fb_addr_o), 32'h0);
        checkOutput("rst_fb_data", 32'(bus.fb_data_o), 32'h0);
        RST = 1'b0;

        // Single read, bridge answers 3 cycles after fb_start.
        bridgeDelay = 3;
        applyStimulus(0, 1'b1, 8'h3C, 8'h00);
        expectDone(0, 1'b0, 4);
        bus.req_i[0] = 1'b1;
        waitDrain(30);
        stepCycle();
        checkOutput("read_grant_released", 32'(bus.grant_o), 32'h0);
        checkOutput("read_busy_released", 32'(bus.busy_o), 32'h0);
        checkOutput("read_fb_addr_hold", 32'(bus.fb_addr_o), 32'h3C);

        // Timeout: bridge silent, err after TIMEOUT cycles in WAIT.
        bridgeDelay = 0;
        applyStimulus(0, 1'b0, 8'h5A, 8'h77);
        expectDone(0, 1'b1, TIMEOUT + 1);
        bus.req_i[0] = 1'b1;
        waitDrain(40);

        // Following request from requester 1 is served normally.
        bridgeDelay = 2;
        applyStimulus(1, 1'b1, 8'hC3, 8'h00);
        expectDone(1, 1'b0, 3);
        bus.req_i[1] = 1'b1;
        waitDrain(30);

        // Contention with re-raise: 0,1,0,1.
        applyStimulus(0, 1'b0, 8'hA0, 8'h5A);
        applyStimulus(1, 1'b1, 8'hB1, 8'h00);
        expectDone(0, 1'b0, 3);
        expectDone(1, 1'b0, 3);
        expectDone(0, 1'b0, 3);
        expectDone(1, 1'b0, 3);
        reRaiseLeft = '{1, 1};
        bus.req_i = 2'b11;
        waitDrain(60);
        stepCycle();
        checkOutput("contention_idle", 32'(bus.busy_o), 32'h0);

        // Address latched at grant; later change ignored.
        bridgeDelay = 4;
        applyStimulus(0, 1'b1, 8'h11, 8'h00);
        expectDone(0, 1'b0, 5);
        bus.req_i[0] = 1'b1;
        for (int k = 0; k < 10 && bus.grant_o[0] !== 1'b1; k++) stepCycle();
        checkOutput("latch_grant", 32'(bus.grant_o), 32'h1);
        bus.req_addr_i[7:0] = 8'h22;
        stepCycle();
        checkOutput("latch_mid", 32'(bus.fb_addr_o), 32'h11);
        waitDrain(30);

        // fb_done on the same cycle the watchdog reaches TIMEOUT-1: ack wins.
        bridgeDelay = TIMEOUT;
        applyStimulus(0, 1'b0, 8'h44, 8'h99);
        expectDone(0, 1'b0, TIMEOUT + 1);
        bus.req_i[0] = 1'b1;
        waitDrain(40);

        // Reset during WAIT: no ack/err, late fb_done ignored, pointer back to requester 0 first.
        bridgeDelay = 5;
        applyStimulus(0, 1'b1, 8'h66, 8'h00);
        bus.req_i[0] = 1'b1;
        for (int k = 0; k < 10 && bus.fb_start_o !== 1'b1; k++) stepCycle();
        checkOutput("rst_wait_start", 32'(bus.fb_start_o), 32'h1);
        stepCycle();
        RST = 1'b1;
        bus.req_i = 2'b00;
        stepCycle();
        RST = 1'b0;
        startsSeen = 0;
        prevStart  = 1'b0;
        checkOutput("rst_wait_grant", 32'(bus.grant_o), 32'h0);
        checkOutput("rst_wait_busy", 32'(bus.busy_o), 32'h0);
        checkOutput("rst_wait_fb_addr", 32'(bus.fb_addr_o), 32'h0);
        repeat (8) stepCycle();
        checkOutput("rst_wait_still_idle", 32'(bus.busy_o), 32'h0);

        bridgeDelay = 2;
        applyStimulus(0, 1'b1, 8'h0F, 8'h00);
        applyStimulus(1, 1'b0, 8'hF0, 8'hAB);
        expectDone(0, 1'b0, 3);
        expectDone(1, 1'b0, 3);
        reRaiseLeft = '{0, 0};
        bus.req_i = 2'b11;
        waitDrain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
